// File: rtl/data_sram_resp_pkg.sv
// Shared widths and FSM encoding for the MEM-stage data-SRAM responder.
package data_sram_resp_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ADDR_BUS_W = 32;
  localparam int unsigned SEL_W      = 4;
  localparam int unsigned LANE_W     = 8;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/data_sram_resp_array.sv
// Byte-lane word memory: synchronous per-lane write, registered (resettable) read port.
module data_sram_array
  import data_sram_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SEL_W-1:0]      we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic                  rd_en_i,
  input  logic                  rd_clr_i,
  output logic [DATA_W-1:0]     rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage is deliberately not reset; contents survive rst.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(SEL_W); i++) begin
      if (we_i[i]) begin
        mem_q[addr_i][LANE_W*i +: LANE_W] <= wdata_i[LANE_W*i +: LANE_W];
      end
    end
  end

  // Read register holds its value until the next load access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (rd_en_i) begin
      rdata_q <= rd_clr_i ? '0 : mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_resp.sv
// MEM-stage data-memory responder: one request at a time, WAIT_CYCLES wait states, stall back-pressure.
// Optional out-of-range error reporting under `define DATA_SRAM_ERR_EN.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_en,
  input  logic                  req_write,
  input  logic [SEL_W-1:0]      req_sel,
  input  logic [ADDR_BUS_W-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_valid,
  output logic                  stall
`ifdef DATA_SRAM_ERR_EN
  ,
  output logic                  resp_err
`endif
);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  valid_q;

  logic                  acc;
  logic                  use_live;
  logic                  acc_wr;
  logic [SEL_W-1:0]      acc_sel;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_W-1:0]     acc_wdata;
  logic                  acc_oor;
  logic [SEL_W-1:0]      arr_we;
  logic                  arr_rd;

  // Next-state: capture in IDLE, count down in WAIT, single DONE cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    acc      = 1'b0;
    use_live = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_en) begin
          wr_d    = req_write;
          sel_d   = req_sel;
          addr_d  = req_addr[ADDR_WIDTH+1:2];
          wdata_d = req_wdata;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_d  = S_DONE;
            acc      = 1'b1;
            use_live = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          acc     = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Zero-wait accesses happen on the capture edge, before the latches hold the request.
  assign acc_wr    = use_live ? req_write : wr_q;
  assign acc_sel   = use_live ? req_sel : sel_q;
  assign acc_addr  = use_live ? req_addr[ADDR_WIDTH+1:2] : addr_q;
  assign acc_wdata = use_live ? req_wdata : wdata_q;

`ifdef DATA_SRAM_ERR_EN
  logic oor_q, oor_d, err_q;

  assign oor_d   = (state_q == S_IDLE && req_en) ? ((req_addr >> (ADDR_WIDTH + 2)) != '0) : oor_q;
  assign acc_oor = use_live ? oor_d : oor_q;
  assign resp_err = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oor_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      oor_q <= oor_d;
      err_q <= (state_d == S_DONE) && acc_oor;
    end
  end
`else
  assign acc_oor = 1'b0;
`endif

  assign arr_we = (acc && acc_wr && !acc_oor) ? acc_sel : '0;
  assign arr_rd = acc && !acc_wr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      valid_q <= (state_d == S_DONE);
    end
  end

  assign resp_valid = valid_q;
  assign stall      = req_en && (state_q != S_DONE);

  data_sram_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (arr_we),
    .addr_i  (acc_addr),
    .wdata_i (acc_wdata),
    .rd_en_i (arr_rd),
    .rd_clr_i(acc_oor),
    .rdata_o (resp_rdata)
  );

  // Byte-offset bits and (in the wrapping build) high address bits are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^{req_addr[1:0], req_addr[ADDR_BUS_W-1:ADDR_WIDTH+2]};

endmodule
